low_freq_meter_param_amisha: RTL and testbench

//  Parametrised period-based low-frequency meter, successor of the fixed 4-digit counter.
//  - Measures the input period in TICK_HZ ticks over NUM_PERIODS consecutive periods.
//  - Computes f = TICK_HZ*NUM_PERIODS/ticks with a sequential divider.
//  - Converts the quotient to DIGITS BCD digits for the seven-segment display path.

---
 rtl/low_freq_meter_param_amisha.sv | 222 ++++++++++++++++++++++
 tb/tb_low_freq_meter_param_amisha.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/low_freq_meter_param_amisha.sv
// +----------------------------------------------------------------------------+
// | low_freq_meter_param_amisha: period-based low-frequency meter with BCD out |
// | Optional watchdog: LFM_TIMEOUT_EN.  Rev 1.0                                |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module low_freq_meter_param_amisha #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1_000_000,
  parameter int NUM_PERIODS = 1,
  parameter int DIGITS      = 4,
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_TK  = 2_000_000
) (
  input  logic                  clk_amisha,
  input  logic                  reset_amisha,
  input  logic                  start_amisha,
  input  logic                  si_amisha,
  output logic                  busy_amisha,
  output logic                  done_tick_amisha,
  output logic                  ovf_amisha,
  output logic                  tmo_amisha,
  output logic [4*DIGITS-1:0]   bcd_amisha
);

  localparam int          PRESC    = CLK_HZ / TICK_HZ;
  localparam int          PS_W     = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam longint      DIVIDEND = longint'(TICK_HZ) * NUM_PERIODS;
  localparam int          DIV_W    = $clog2(DIVIDEND + 1);
  localparam int          STEP_W   = $clog2(DIV_W + 1);
  localparam int          IDX_W    = $clog2(NUM_PERIODS) + 1;
  localparam logic [63:0] BCD_LIMIT = 64'(10 ** DIGITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_BCD   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]          state;
  logic                s1, s2, s3;
  logic [PS_W-1:0]     presc;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    rem;
  logic [DIV_W-1:0]    quo;
  logic [STEP_W-1:0]   step;
  logic [4*DIGITS-1:0] dd;
  logic [4*DIGITS-1:0] dd_adj;
  logic [4*DIGITS-1:0] dd_next;
  logic [4*DIGITS-1:0] bcd;
  logic                ovf;
  logic                sat;

  logic                si_rise;
  logic                tick;
  logic [CNT_W:0]      trial;
  logic                ge;
  logic [CNT_W-1:0]    diff;
  logic                shift_in;
  logic [DIV_W-1:0]    shifted;
  logic                last_step;
  logic                force_zero;

  assign si_rise    = s2 & ~s3;
  assign tick       = (presc == PS_W'(PRESC - 1));
  assign trial      = {rem, quo[DIV_W-1]};
  assign ge         = (trial >= {1'b0, cnt});
  assign diff       = trial[CNT_W-1:0] - cnt;
  assign shift_in   = (state == S_DIV) ? ge : 1'b0;
  assign last_step  = (step == STEP_W'(DIV_W - 1));
  assign force_zero = ovf | (cnt == '0);

  // quo doubles as dividend shifter in DIV and quotient shifter in BCD
  if (DIV_W > 1) begin : g_shift_wide
    assign shifted = {quo[DIV_W-2:0], shift_in};
  end else begin : g_shift_bit
    assign shifted = shift_in;
  end

  always_comb begin
    dd_adj = dd;
    for (int i = 0; i < DIGITS; i++) begin
      if (dd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd[4*i +: 4] + 4'd3;
    end
  end
  assign dd_next = {dd_adj[4*DIGITS-2:0], quo[DIV_W-1]};

`ifdef LFM_TIMEOUT_EN
  logic [31:0] wd;
  logic        tmo;
`endif

  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      state <= S_IDLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      presc <= '0;
      cnt   <= '0;
      idx   <= '0;
      rem   <= '0;
      quo   <= '0;
      step  <= '0;
      dd    <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
      sat   <= 1'b0;
`ifdef LFM_TIMEOUT_EN
      wd    <= '0;
      tmo   <= 1'b0;
`endif
    end else begin
      s1 <= si_amisha;
      s2 <= s1;
      s3 <= s2;

      if ((state == S_WAIT && si_rise) || tick) presc <= '0;
      else                                      presc <= presc + PS_W'(1);

      case (state)
        S_IDLE: begin
          if (start_amisha) begin
            state <= S_WAIT;
            ovf   <= 1'b0;
            sat   <= 1'b0;
`ifdef LFM_TIMEOUT_EN
            tmo   <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (si_rise) begin
            state <= S_COUNT;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        S_COUNT: begin
          if (tick) begin
            if (&cnt) ovf <= 1'b1;
            else      cnt <= cnt + CNT_W'(1);
          end
          if (si_rise) begin
            if (idx == IDX_W'(NUM_PERIODS - 1)) begin
              state <= S_DIV;
              rem   <= '0;
              quo   <= DIV_W'(DIVIDEND);
              step  <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DIV: begin
          rem  <= ge ? diff : trial[CNT_W-1:0];
          quo  <= shifted;
          step <= step + STEP_W'(1);
          if (last_step) begin
            state <= S_BCD;
            step  <= '0;
            dd    <= '0;
            if (force_zero) begin
              quo <= '0;
            end else if (64'(shifted) >= BCD_LIMIT) begin
              sat <= 1'b1;
              ovf <= 1'b1;
            end
          end
        end
        S_BCD: begin
          dd   <= dd_next;
          quo  <= shifted;
          step <= step + STEP_W'(1);
          if (last_step) begin
            state <= S_DONE;
            bcd   <= sat ? {DIGITS{4'h9}} : dd_next;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

`ifdef LFM_TIMEOUT_EN
      // watchdog overrides the FSM when si goes quiet
      if (state == S_WAIT || state == S_COUNT) begin
        if (si_rise) begin
          wd <= '0;
        end else if (tick) begin
          if (wd == 32'(TIMEOUT_TK - 1)) begin
            wd    <= '0;
            tmo   <= 1'b1;
            bcd   <= '0;
            state <= S_DONE;
          end else begin
            wd <= wd + 32'd1;
          end
        end
      end else begin
        wd <= '0;
      end
`endif
    end
  end

  assign busy_amisha      = (state != S_IDLE) && (state != S_DONE);
  assign done_tick_amisha = (state == S_DONE);
  assign ovf_amisha       = ovf;
  assign bcd_amisha       = bcd;
`ifdef LFM_TIMEOUT_EN
  assign tmo_amisha       = tmo;
`else
  // constant 0; the comparison only keeps TIMEOUT_TK referenced
  assign tmo_amisha       = (TIMEOUT_TK < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_low_freq_meter_param_amisha.sv
// Scoreboard bench for low_freq_meter_param_amisha: random si periods checked
// against an arithmetic frequency/BCD model, one DUT per NUM_PERIODS setting.
`default_nettype none
`timescale 1ns/1ps

module tb_low_freq_meter_param_amisha;

  localparam longint TICK = 1_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  logic si = 1'b0;
  logic busy1, done1, ovf1, tmo1;
  logic busy4, done4, ovf4, tmo4;
  logic [15:0] bcd1, bcd4;

  always #5 clk = ~clk;

  low_freq_meter_param_amisha #(
    .CLK_HZ(1_000_000), .TICK_HZ(1_000_000), .NUM_PERIODS(1),
    .DIGITS(4), .CNT_W(24), .TIMEOUT_TK(5000)
  ) dut1 (
    .clk_amisha(clk), .reset_amisha(rst_n), .start_amisha(start1), .si_amisha(si),
    .busy_amisha(busy1), .done_tick_amisha(done1), .ovf_amisha(ovf1),
    .tmo_amisha(tmo1), .bcd_amisha(bcd1)
  );

  low_freq_meter_param_amisha #(
    .CLK_HZ(1_000_000), .TICK_HZ(1_000_000), .NUM_PERIODS(4),
    .DIGITS(4), .CNT_W(24), .TIMEOUT_TK(5000)
  ) dut4 (
    .clk_amisha(clk), .reset_amisha(rst_n), .start_amisha(start4), .si_amisha(si),
    .busy_amisha(busy4), .done_tick_amisha(done4), .ovf_amisha(ovf4),
    .tmo_amisha(tmo4), .bcd_amisha(bcd4)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic        tmo;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // frequency = TICK*n / (ticks over n periods), truncated, then decimal digits
  function automatic exp_t model(input int p, input int n);
    exp_t   e;
    longint f;
    f = (TICK * n) / (longint'(p) * n);
    e.tmo = 1'b0;
    if (f >= 10000) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      e.bcd = '0;
      for (int i = 0; i < 4; i++) e.bcd[4*i +: 4] = 4'((f / (10 ** i)) % 10);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL done1_unexpected: got done_tick expected none");
      end else begin
        e = q1.pop_front();
        check("bcd1", 32'(bcd1), 32'(e.bcd));
        check("ovf1", 32'(ovf1), 32'(e.ovf));
        check("tmo1", 32'(tmo1), 32'(e.tmo));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        checks++;
        $display("FAIL done4_unexpected: got done_tick expected none");
      end else begin
        e = q4.pop_front();
        check("bcd4", 32'(bcd4), 32'(e.bcd));
        check("ovf4", 32'(ovf4), 32'(e.ovf));
        check("tmo4", 32'(tmo4), 32'(e.tmo));
      end
    end
  end

  task automatic set_start(input bit use4, input logic v);
    if (use4) start4 = v;
    else      start1 = v;
  endtask

  function automatic logic get_busy(input bit use4);
    return use4 ? busy4 : busy1;
  endfunction

  task automatic wait_idle(input bit use4, input int budget);
    int k;
    for (k = 0; k < budget && get_busy(use4); k++) @(negedge clk);
    check(use4 ? "idle4_bound" : "idle1_bound", 32'(get_busy(use4)), 32'd0);
  endtask

  // one measurement; optionally pulse start while the divider runs
  task automatic measure(input bit use4, input int p, input bit poke_div);
    int n, h, l;
    n = use4 ? 4 : 1;
    h = p / 2;
    l = p - h;
    if (use4) q4.push_back(model(p, 4));
    else      q1.push_back(model(p, 1));
    @(negedge clk); set_start(use4, 1'b1);
    @(negedge clk); set_start(use4, 1'b0);
    check(use4 ? "busy4_after_start" : "busy1_after_start", 32'(get_busy(use4)), 32'd1);
    repeat (5) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      si = 1'b1; repeat (h) @(negedge clk);
      si = 1'b0; repeat (l) @(negedge clk);
    end
    si = 1'b1;
    repeat (8) @(negedge clk);
    if (poke_div) set_start(use4, 1'b1);
    repeat (2) @(negedge clk);
    set_start(use4, 1'b0);
    si = 1'b0;
    wait_idle(use4, 200);
    repeat (3) @(negedge clk);
    check(use4 ? "busy4_stays_low" : "busy1_stays_low", 32'(get_busy(use4)), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_done",  32'(done1), 32'd0);
    check("rst_ovf",   32'(ovf1),  32'd0);
    check("rst_tmo",   32'(tmo1),  32'd0);
    check("rst_bcd",   32'(bcd1),  32'd0);
    check("rst_bcd4",  32'(bcd4),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    measure(1'b0, 1000, 1'b0);
    measure(1'b0, 3000, 1'b0);
    measure(1'b0, 400,  1'b1);
    measure(1'b0, 3,    1'b0);
    measure(1'b1, 500,  1'b0);

    // abort mid-count: no done_tick, everything back to zero
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(negedge clk);
    si = 1'b1; repeat (500) @(negedge clk);
    si = 1'b0; repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_done", 32'(done1), 32'd0);
    check("abort_ovf",  32'(ovf1),  32'd0);
    check("abort_bcd",  32'(bcd1),  32'd0);
    repeat (100) @(negedge clk);
    check("abort_still_idle", 32'(busy1), 32'd0);
    measure(1'b0, 1000, 1'b0);

    for (int r = 0; r < 6; r++) measure(1'b0, int'($urandom_range(3, 2000)), r[0]);
    for (int r = 0; r < 2; r++) measure(1'b1, int'($urandom_range(3, 800)), 1'b0);

`ifdef LFM_TIMEOUT_EN
    begin
      exp_t e;
      e.bcd = '0; e.ovf = 1'b0; e.tmo = 1'b1;
      q1.push_back(e);
      si = 1'b0;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      wait_idle(1'b0, 6000);
    end
`endif

    repeat (5) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
